pwm_capture: RTL and testbench

- Receive-side counterpart of the team's PWM generator: measures an incoming PWM waveform and reports period, high time and duty in percent.
- Sits downstream of any PWM source (generator loopback, external fan/servo line) on the same `clkin` domain.
- Result is used for closed-loop duty checking and for display.

---
 rtl/pwm_pkg.sv | 14 +
 rtl/pwm_pct_div.sv | 70 +++++++
 rtl/pwm_capture.sv | 220 ++++++++++++++++++++++
 tb/tb_pwm_capture.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared constants and FSM state type for the PWM capture block.
package pwm_pkg;

    localparam int DUTY_W    = 7;
    localparam int PCT_SCALE = 100;
    localparam int DIV_ITER  = 7;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEAS    = 2'd1,
        TIMEOUT = 2'd2
    } state_t;

endpackage

// File: rtl/pwm_pct_div.sv
// Iterative restoring divider: quotient = floor(high*PCT_SCALE/period), one quotient bit per cycle.
module pwm_pct_div
    import pwm_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic              clkin,
    input  logic              reset,
    input  logic              start,
    input  logic [CNT_W-1:0]  high,
    input  logic [CNT_W-1:0]  period,
    output logic              busy,
    output logic              done,
    output logic [DUTY_W-1:0] quotient
);

    localparam int NUM_W = CNT_W + DUTY_W;
    localparam int IT_W  = $clog2(DIV_ITER);

    logic [NUM_W-1:0]  rem_r;
    logic [NUM_W-1:0]  den_r;
    logic [NUM_W-1:0]  shifted_s;
    logic [NUM_W-1:0]  rem_s;
    logic [IT_W-1:0]   iter_r;
    logic [DUTY_W-2:0] q_r;
    logic              busy_r;
    logic              bit_s;

    // Trial subtraction of the divisor aligned to the current quotient bit.
    always_comb begin
        shifted_s = den_r << iter_r;
        bit_s     = (rem_r >= shifted_s);
        if (bit_s) begin
            rem_s = rem_r - shifted_s;
        end else begin
            rem_s = rem_r;
        end
    end

    // The final bit is presented combinationally so the caller can register it in the done cycle.
    assign busy     = busy_r;
    assign done     = busy_r && (iter_r == IT_W'(0));
    assign quotient = {q_r, bit_s};

    // Operand load on start, then one restoring step per cycle.
    always_ff @(posedge clkin) begin
        if (reset) begin
            rem_r  <= NUM_W'(0);
            den_r  <= NUM_W'(0);
            iter_r <= IT_W'(0);
            q_r    <= (DUTY_W-1)'(0);
            busy_r <= 1'b0;
        end else if (start) begin
            rem_r  <= NUM_W'(high) * NUM_W'(PCT_SCALE);
            den_r  <= NUM_W'(period);
            iter_r <= IT_W'(DIV_ITER - 1);
            q_r    <= (DUTY_W-1)'(0);
            busy_r <= 1'b1;
        end else if (busy_r) begin
            rem_r <= rem_s;
            q_r   <= quotient[DUTY_W-2:0];
            if (iter_r == IT_W'(0)) begin
                busy_r <= 1'b0;
            end else begin
                iter_r <= iter_r - IT_W'(1);
            end
        end
    end

endmodule

// File: rtl/pwm_capture.sv
// Measures period, high time and duty (percent) of an asynchronous PWM input on clkin.
// Build option: define GLITCH_FILTER_EN to add a FILT_LEN-sample glitch filter after the synchroniser.
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 3
) (
    input  logic              clkin,
    input  logic              reset,
    input  logic              pwm_in,
    output logic [CNT_W-1:0]  period_o,
    output logic [CNT_W-1:0]  high_o,
    output logic [DUTY_W-1:0] duty_pct,
    output logic              valid,
    output logic              timeout,
    output logic              overrun
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    if (SYNC_STAGES < 2 || FILT_LEN < 1) begin : g_param_check
        $error("pwm_capture: SYNC_STAGES must be >= 2 and FILT_LEN >= 1");
    end

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   synced_s;
    logic                   level_s;
    logic                   prev_r;
    logic                   rise_s;
    state_t                 state_r;
    state_t                 state_s;
    logic [CNT_W-1:0]       per_cnt_r;
    logic [CNT_W-1:0]       high_cnt_r;
    logic [CNT_W-1:0]       cap_per_r;
    logic [CNT_W-1:0]       cap_high_r;
    logic [CNT_W-1:0]       period_r;
    logic [CNT_W-1:0]       high_r;
    logic [DUTY_W-1:0]      duty_r;
    logic [DUTY_W-1:0]      div_q_s;
    logic                   capture_s;
    logic                   drop_s;
    logic                   to_enter_s;
    logic                   div_busy_s;
    logic                   div_done_s;
    logic                   valid_r;
    logic                   timeout_r;
    logic                   overrun_r;

    // Input synchroniser.
    always_ff @(posedge clkin) begin
        if (reset) begin
            sync_r <= SYNC_STAGES'(0);
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], pwm_in};
        end
    end

    assign synced_s = sync_r[SYNC_STAGES-1];

`ifdef GLITCH_FILTER_EN
    localparam int FC_W = $clog2(FILT_LEN + 1);

    logic [FC_W-1:0] filt_cnt_r;
    logic            filt_r;

    // Output follows the input only after FILT_LEN consecutive differing samples.
    always_ff @(posedge clkin) begin
        if (reset) begin
            filt_cnt_r <= FC_W'(0);
            filt_r     <= 1'b0;
        end else if (synced_s != filt_r) begin
            if (filt_cnt_r == FC_W'(FILT_LEN - 1)) begin
                filt_r     <= synced_s;
                filt_cnt_r <= FC_W'(0);
            end else begin
                filt_cnt_r <= filt_cnt_r + FC_W'(1);
            end
        end else begin
            filt_cnt_r <= FC_W'(0);
        end
    end

    assign level_s = filt_r;
`else
    assign level_s = synced_s;
`endif

    // Previous level for edge detection.
    always_ff @(posedge clkin) begin
        if (reset) begin
            prev_r <= 1'b0;
        end else begin
            prev_r <= level_s;
        end
    end

    assign rise_s = level_s & ~prev_r;

    // FSM state register.
    always_ff @(posedge clkin) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next state plus capture / drop / timeout-entry strobes.
    always_comb begin
        state_s    = state_r;
        capture_s  = 1'b0;
        drop_s     = 1'b0;
        to_enter_s = 1'b0;
        case (state_r)
            IDLE, TIMEOUT: begin
                if (rise_s) begin
                    state_s = MEAS;
                end else begin
                    state_s = state_r;
                end
            end
            MEAS: begin
                if (rise_s) begin
                    if (div_busy_s) begin
                        drop_s = 1'b1;
                    end else begin
                        capture_s = 1'b1;
                    end
                end else if (per_cnt_r == CNT_MAX) begin
                    state_s    = TIMEOUT;
                    to_enter_s = 1'b1;
                end else begin
                    state_s = MEAS;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Period and high-time counters; both restart at 1 on every detected rise.
    always_ff @(posedge clkin) begin
        if (reset) begin
            per_cnt_r  <= CNT_W'(0);
            high_cnt_r <= CNT_W'(0);
        end else if (rise_s) begin
            per_cnt_r  <= CNT_W'(1);
            high_cnt_r <= CNT_W'(1);
        end else if (state_r == MEAS) begin
            per_cnt_r <= per_cnt_r + CNT_W'(1);
            if (level_s) begin
                high_cnt_r <= high_cnt_r + CNT_W'(1);
            end
        end
    end

    pwm_pct_div #(
        .CNT_W (CNT_W)
    ) u_div (
        .clkin    (clkin),
        .reset    (reset),
        .start    (capture_s),
        .high     (high_cnt_r),
        .period   (per_cnt_r),
        .busy     (div_busy_s),
        .done     (div_done_s),
        .quotient (div_q_s)
    );

    // Result registers; the captured pair is held until its quotient is ready.
    always_ff @(posedge clkin) begin
        if (reset) begin
            cap_per_r  <= CNT_W'(0);
            cap_high_r <= CNT_W'(0);
            period_r   <= CNT_W'(0);
            high_r     <= CNT_W'(0);
            duty_r     <= DUTY_W'(0);
            valid_r    <= 1'b0;
            timeout_r  <= 1'b0;
            overrun_r  <= 1'b0;
        end else begin
            if (capture_s) begin
                cap_per_r  <= per_cnt_r;
                cap_high_r <= high_cnt_r;
            end
            if (to_enter_s) begin
                period_r <= CNT_MAX;
                high_r   <= level_s ? CNT_MAX : CNT_W'(0);
                duty_r   <= level_s ? DUTY_W'(PCT_SCALE) : DUTY_W'(0);
                valid_r  <= 1'b1;
            end else if (div_done_s) begin
                period_r <= cap_per_r;
                high_r   <= cap_high_r;
                duty_r   <= div_q_s;
                valid_r  <= 1'b1;
            end else begin
                valid_r <= 1'b0;
            end
            if (to_enter_s) begin
                timeout_r <= 1'b1;
            end else if (rise_s) begin
                timeout_r <= 1'b0;
            end
            if (drop_s) begin
                overrun_r <= 1'b1;
            end
        end
    end

    assign period_o = period_r;
    assign high_o   = high_r;
    assign duty_pct = duty_r;
    assign valid    = valid_r;
    assign timeout  = timeout_r;
    assign overrun  = overrun_r;

endmodule

// File: tb/tb_pwm_capture.sv
// Randomised scoreboard bench for pwm_capture; expectations come from a rise-time model of the input.
module tb_pwm_capture;

    localparam int CNT_W = 10;
    localparam int SYNC  = 2;
    localparam int FILT  = 3;
`ifdef GLITCH_FILTER_EN
    localparam bit FILTER_ON = 1'b1;
`else
    localparam bit FILTER_ON = 1'b0;
`endif
    localparam int IN_LAT = SYNC + (FILTER_ON ? FILT : 0);
    localparam int CMAX   = (1 << CNT_W) - 1;

    logic             clkin  = 1'b0;
    logic             reset  = 1'b1;
    logic             pwm_in = 1'b0;
    logic [CNT_W-1:0] period_o;
    logic [CNT_W-1:0] high_o;
    logic [6:0]       duty_pct;
    logic             valid;
    logic             timeout;
    logic             overrun;

    pwm_capture #(
        .CNT_W       (CNT_W),
        .SYNC_STAGES (SYNC),
        .FILT_LEN    (FILT)
    ) dut (
        .clkin    (clkin),
        .reset    (reset),
        .pwm_in   (pwm_in),
        .period_o (period_o),
        .high_o   (high_o),
        .duty_pct (duty_pct),
        .valid    (valid),
        .timeout  (timeout),
        .overrun  (overrun)
    );

    always #5 clkin = ~clkin;

    int cyc = 0;
    always @(posedge clkin) cyc <= cyc + 1;

    typedef struct {
        int t;
        int per;
        int hi;
        int duty;
        int to;
    } exp_t;

    exp_t sbq[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model state: 0 idle, 1 measuring, 2 timed out (all times in input cycles).
    int m_state;
    int m_last;
    int m_high;
    int m_busy_end;
    bit m_prev;
    bit exp_ovr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_state    = 0;
        m_last     = 0;
        m_high     = 0;
        m_busy_end = 0;
        m_prev     = 1'b0;
        exp_ovr    = 1'b0;
        sbq.delete();
    endtask

    task automatic model_cycle(input bit lvl, input int k);
        exp_t e;
        if (lvl && !m_prev) begin
            if (m_state == 1) begin
                if (k < m_busy_end) begin
                    exp_ovr = 1'b1;
                end else begin
                    e.t    = k + IN_LAT + 8;
                    e.per  = k - m_last;
                    e.hi   = m_high;
                    e.duty = (m_high * 100) / (k - m_last);
                    e.to   = 0;
                    sbq.push_back(e);
                    m_busy_end = k + 8;
                end
            end
            m_state = 1;
            m_last  = k;
            m_high  = 0;
        end else if (m_state == 1 && (k - m_last) == CMAX) begin
            e.t    = m_last + IN_LAT + CMAX + 1;
            e.per  = CMAX;
            e.hi   = lvl ? CMAX : 0;
            e.duty = lvl ? 100 : 0;
            e.to   = 1;
            sbq.push_back(e);
            m_state = 2;
        end
        if (lvl && m_state == 1) m_high++;
        m_prev = lvl;
    endtask

    task automatic drive_seg(input bit lvl, input int n, input bit seen);
        for (int i = 0; i < n; i++) begin
            @(posedge clkin);
            #1;
            pwm_in = lvl;
            if (seen) model_cycle(lvl, cyc);
        end
    endtask

    task automatic pulse(input int hi, input int lo, input int reps);
        for (int r = 0; r < reps; r++) begin
            drive_seg(1'b1, hi, 1'b1);
            drive_seg(1'b0, lo, 1'b1);
        end
    endtask

    task automatic do_reset(input int n);
        @(posedge clkin);
        #1;
        reset  = 1'b1;
        pwm_in = 1'b0;
        model_reset();
        repeat (n) @(posedge clkin);
        #1;
        reset = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_period"},  period_o, 0);
        check({tag, "_high"},    high_o,   0);
        check({tag, "_duty"},    duty_pct, 0);
        check({tag, "_valid"},   valid,    0);
        check({tag, "_timeout"}, timeout,  0);
        check({tag, "_overrun"}, overrun,  0);
    endtask

    // Monitor: every valid pops one expectation and checks timing and all result fields.
    always @(negedge clkin) begin : monitor
        exp_t e;
        if (valid === 1'b1) begin
            n_cmp++;
            if (sbq.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_valid: cycle %0d period=%0d high=%0d duty=%0d, none expected",
                         cyc, period_o, high_o, duty_pct);
            end else begin
                e = sbq.pop_front();
                if (cyc != e.t || 32'(period_o) !== 32'(e.per) || 32'(high_o) !== 32'(e.hi) ||
                    32'(duty_pct) !== 32'(e.duty) || 32'(timeout) !== 32'(e.to)) begin
                    n_bad++;
                    $display("FAIL result: got cyc=%0d per=%0d hi=%0d duty=%0d to=%0d, expected cyc=%0d per=%0d hi=%0d duty=%0d to=%0d",
                             cyc, period_o, high_o, duty_pct, timeout, e.t, e.per, e.hi, e.duty, e.to);
                end
            end
        end
    end

    initial begin
        model_reset();
        do_reset(4);
        check_zero("reset");

        drive_seg(1'b0, 10, 1'b1);
        pulse(25, 25, 4);
        pulse(5, 45, 3);
        pulse(45, 5, 3);
        drive_seg(1'b0, 20, 1'b1);
        check("basic_drained", sbq.size(), 0);
        check("basic_overrun", overrun, exp_ovr);

        for (int i = 0; i < 25; i++) begin
            int p;
            int h;
            p = $urandom_range(60, 9);
            h = $urandom_range(p - 3, 3);
            pulse(h, p - h, 1);
        end
        drive_seg(1'b0, 20, 1'b1);
        check("random_drained", sbq.size(), 0);
        check("random_overrun", overrun, exp_ovr);

        drive_seg(1'b0, CMAX + 40, 1'b1);
        check("timeout_low", timeout, 1);
        check("timeout_low_drained", sbq.size(), 0);
        drive_seg(1'b1, CMAX + 40, 1'b1);
        check("timeout_high", timeout, 1);
        drive_seg(1'b0, 30, 1'b1);
        drive_seg(1'b1, 20, 1'b1);
        check("timeout_cleared", timeout, 0);
        drive_seg(1'b0, 30, 1'b1);
        pulse(20, 30, 3);
        drive_seg(1'b0, 20, 1'b1);
        check("recover_drained", sbq.size(), 0);

        pulse(3, 3, 10);
        drive_seg(1'b0, 20, 1'b1);
        check("overrun_sticky", overrun, 1);
        check("overrun_model", overrun, exp_ovr);
        check("overrun_drained", sbq.size(), 0);

        drive_seg(1'b0, 20, 1'b1);
        pulse(25, 25, 1);
        drive_seg(1'b1, IN_LAT + 3, 1'b1);
        do_reset(3);
        check_zero("midbusy");
        drive_seg(1'b0, 10, 1'b1);
        pulse(25, 25, 2);
        drive_seg(1'b0, 20, 1'b1);
        check("post_reset_drained", sbq.size(), 0);

        for (int r = 0; r < 4; r++) begin
            drive_seg(1'b1, 25, 1'b1);
            drive_seg(1'b0, 10, 1'b1);
            drive_seg(1'b1, 2, !FILTER_ON);
            drive_seg(1'b0, 13, 1'b1);
        end
        drive_seg(1'b0, 30, 1'b1);
        check("glitch_drained", sbq.size(), 0);
        check("glitch_overrun", overrun, exp_ovr);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
